fir_serial_mac: RTL and testbench
=================================

Name: fir_serial_mac

Overview:
Parametrised, time-multiplexed FIR filter for the fixed-point FIR family. It uses a single multiply-accumulate unit that steps through NUM_TAPS taps per input sample. It replaces the fully parallel fixed-tap FIR with three additions: a runtime-writable coefficient bank, valid/ready handshakes on both sides, and selectable output saturation. It sits between the sample source and the output quantiser/sink in the filter datapath.

Parameters:
NUM_TAPS, 16, filter order + 1; must be >= 2
COE_INTE_WL, 4, coefficient integer bits, sign bit included
COE_FRAC_WL, 8, coefficient fractional bits
IN_INTE_WL, 4, input integer bits, sign bit included
IN_FRAC_WL, 8, input fractional bits
OUT_INTE_WL, 4, output integer bits, sign bit included
OUT_FRAC_WL, 8, output fractional bits
ACC_FRAC_WL, 16, fractional bits kept per product; must be <= COE_FRAC_WL+IN_FRAC_WL and >= OUT_FRAC_WL
SAT_EN, 1, 1 = saturate output, 0 = two's-complement wrap

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
data_in  in  IN_INTE_WL+IN_FRAC_WL  signed input sample
in_valid  in  1  data_in is valid
in_ready  out  1  block can accept a sample
coe_wr_en  in  1  coefficient write strobe
coe_wr_addr  in  clog2(NUM_TAPS)  tap index
coe_wr_data  in  COE_INTE_WL+COE_FRAC_WL  signed coefficient
data_out  out  OUT_INTE_WL+OUT_FRAC_WL  signed filtered sample
out_valid  out  1  data_out is valid
out_ready  in  1  sink accepts data_out
sat_flag  out  1  the current data_out was clipped; valid while out_valid is high

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high.
- Reset values:
  - state = IDLE; delay line, coefficient bank, accumulator and tap counter = 0.
  - data_out = 0, out_valid = 0, sat_flag = 0, in_ready = 1 once rst is released.
- FSM (state type lives in fir_pkg):
  - IDLE:
    - in_ready = 1.
    - On in_valid & in_ready: shift the delay line (x[k] <= x[k-1], x[0] <= data_in), clear acc, k <= 0, go to MAC.
  - MAC:
    - in_ready = 0.
    - Each cycle: acc <= acc + trunc(x[k]*c[k]); k <= k+1.
    - After the tap with k = NUM_TAPS-1, go to OUT.
  - OUT:
    - Register the quantised acc into data_out and sat_flag; out_valid = 1.
    - Hold until out_ready is high; on out_valid & out_ready go to IDLE with out_valid <= 0.
- Latency: sample accepted at cycle T; out_valid rises at T+NUM_TAPS+1. Throughput with out_ready held high is one sample per NUM_TAPS+2 cycles.
- Arithmetic:
  - Product: signed, COE_INTE_WL+IN_INTE_WL integer bits, COE_FRAC_WL+IN_FRAC_WL fractional bits.
  - trunc(): arithmetic right shift (floor) down to ACC_FRAC_WL fractional bits.
  - Accumulator integer bits: COE_INTE_WL+IN_INTE_WL+clog2(NUM_TAPS). It never overflows.
- Output quantiser:
  - Floor to OUT_FRAC_WL fractional bits.
  - SAT_EN=1: clamp to [-2^(OUT_INTE_WL-1), 2^(OUT_INTE_WL-1)-2^-OUT_FRAC_WL]; sat_flag = 1 when a clamp occurred.
  - SAT_EN=0: drop the MSBs (wrap); sat_flag stays 0.
- Coefficient writes:
  - Accepted only in IDLE; take effect on the next accepted sample.
  - coe_wr_en in MAC or OUT is ignored.
  - Simultaneous coe_wr_en and sample acceptance in IDLE: the write lands first, so the new coefficient is used for that sample.
  - coe_wr_addr >= NUM_TAPS is ignored.
- Back-pressure: data_out and sat_flag stay stable while out_valid & !out_ready. No sample is accepted during that time.
- in_valid held low: the block remains in IDLE indefinitely; outputs hold their last values and out_valid = 0.
- rst asserted mid-MAC or mid-OUT: immediate return to reset values. The partial result is discarded and coefficients are cleared.

Decomposition:
- fir_pkg holds:
  - state_t enum {IDLE, MAC, OUT};
  - width functions for product width, accumulator width and the clog2 tap index;
  - quantise constant helpers.
- One sub-module, fir_out_quant: combinational floor, saturate/wrap and sat_flag generation. It is parametrised by the accumulator and output formats plus SAT_EN.

Test Plan:
All scenarios use NUM_TAPS=4, Q4.8 formats throughout, ACC_FRAC_WL=16, out_ready=1 unless stated.
- Impulse response: coefficients all 0x100 (1.0); inputs 0x100 followed by zeros -> data_out 0x100, 0x100, 0x100, 0x100, 0x000. Each out_valid rises 5 cycles after acceptance.
- Saturation: coefficients 0x100; four inputs 0x700 (7.0) -> 4th output is 0x7FF with sat_flag=1. Four inputs 0x800 (-8.0) -> 0x800 with sat_flag=1. Repeat with SAT_EN=0 -> 4th output of the 0x700 run is 0xC00, sat_flag=0.
- Floor rounding: c[0]=0x080 (0.5), others 0.
  - Input 0x001 -> 0x000.
  - Next input 0xFFF (-2^-8) -> 0xFFF.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> data_out stable, in_ready=0, no sample consumed. Releasing out_ready -> out_valid drops next cycle, in_ready=1.
- Coefficient write guard:
  - Write c[1]=0x200 during MAC -> the current and following results are unchanged.
  - Rewrite in IDLE -> the next output reflects 2.0 on tap 1.
- Reset mid-MAC: assert rst at MAC cycle 2 -> out_valid=0, data_out=0 immediately. After release with coefficients reloaded, an impulse reproduces the first scenario from a cleared delay line.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and width helpers for the serial-MAC FIR family.
//   state_t   : controller states
//   idx_w     : width of a tap index
//   prod_w    : full-precision product width
//   acc_w     : accumulator width (guard bits for NUM_TAPS additions)
//   out_max/out_min : two's-complement limits of an output word
package fir_pkg;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   function automatic int unsigned idx_w(input int unsigned taps);
      return (taps > 1) ? $clog2(taps) : 1;
   endfunction

   function automatic int unsigned prod_w(input int unsigned ci, input int unsigned cf,
                                          input int unsigned ii, input int unsigned inf);
      return ci + cf + ii + inf;
   endfunction

   function automatic int unsigned acc_w(input int unsigned ci, input int unsigned ii,
                                         input int unsigned taps, input int unsigned accf);
      return ci + ii + $clog2(taps) + accf;
   endfunction

   function automatic longint out_max(input int unsigned w);
      return (longint'(1) <<< (w - 1)) - 1;
   endfunction

   function automatic longint out_min(input int unsigned w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/fir_out_quant.sv
// Output quantiser: floors the accumulator to the output fraction, then either
// clamps (SAT_EN=1, with sat_o flagging a clip) or wraps by dropping MSBs.
//   acc_i  : signed accumulator, ACC_FRAC_WL fractional bits
//   data_o : signed output word, OUT_FRAC_WL fractional bits
//   sat_o  : high when data_o was clamped
module fir_out_quant
   import fir_pkg::*;
#(
   parameter int unsigned ACC_W       = 26,
   parameter int unsigned ACC_FRAC_WL = 16,
   parameter int unsigned OUT_INTE_WL = 4,
   parameter int unsigned OUT_FRAC_WL = 8,
   parameter bit          SAT_EN      = 1'b1
) (
   input  logic [ACC_W-1:0]                   acc_i,
   output logic [OUT_INTE_WL+OUT_FRAC_WL-1:0] data_o,
   output logic                               sat_o
);

   localparam int unsigned OW = OUT_INTE_WL + OUT_FRAC_WL;
   localparam int unsigned SH = ACC_FRAC_WL - OUT_FRAC_WL;
   localparam int unsigned QW = ACC_W - SH;
   // Extra OW sign bits make the range compare safe for any format mix.
   localparam int unsigned EW = QW + OW;

   localparam logic signed [EW-1:0] MAX_E = EW'(out_max(OW));
   localparam logic signed [EW-1:0] MIN_E = EW'(out_min(OW));

   logic signed [EW-1:0] q_ext;
   logic                 unused_acc;

   // Dropping the low SH bits of a two's-complement value is a floor.
   assign q_ext      = {{OW{acc_i[ACC_W-1]}}, acc_i[ACC_W-1:SH]};
   assign unused_acc = ^acc_i;

   if (SAT_EN) begin : g_sat
      always_comb begin
         data_o = q_ext[OW-1:0];
         sat_o  = 1'b0;
         if (q_ext > MAX_E) begin
            data_o = MAX_E[OW-1:0];
            sat_o  = 1'b1;
         end else if (q_ext < MIN_E) begin
            data_o = MIN_E[OW-1:0];
            sat_o  = 1'b1;
         end
      end
   end else begin : g_wrap
      logic unused_hi;
      assign unused_hi = ^q_ext;
      assign data_o    = q_ext[OW-1:0];
      assign sat_o     = 1'b0;
   end

endmodule

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR: one multiply-accumulate per cycle over NUM_TAPS taps,
// runtime-writable coefficient bank, valid/ready on input and output.
//   clk, rst                       : clock, async active-high reset
//   data_in, in_valid, in_ready    : sample input handshake
//   coe_wr_en/addr/data            : coefficient write port (honoured in IDLE only)
//   data_out, out_valid, out_ready : result output handshake
//   sat_flag                       : data_out was clipped
module fir_serial_mac
   import fir_pkg::*;
#(
   parameter int unsigned NUM_TAPS    = 16,
   parameter int unsigned COE_INTE_WL = 4,
   parameter int unsigned COE_FRAC_WL = 8,
   parameter int unsigned IN_INTE_WL  = 4,
   parameter int unsigned IN_FRAC_WL  = 8,
   parameter int unsigned OUT_INTE_WL = 4,
   parameter int unsigned OUT_FRAC_WL = 8,
   parameter int unsigned ACC_FRAC_WL = 16,
   parameter bit          SAT_EN      = 1'b1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [IN_INTE_WL+IN_FRAC_WL-1:0]   data_in,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic                               coe_wr_en,
   input  logic [idx_w(NUM_TAPS)-1:0]         coe_wr_addr,
   input  logic [COE_INTE_WL+COE_FRAC_WL-1:0] coe_wr_data,
   output logic [OUT_INTE_WL+OUT_FRAC_WL-1:0] data_out,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic                               sat_flag
);

   localparam int unsigned IW    = IN_INTE_WL + IN_FRAC_WL;
   localparam int unsigned CW    = COE_INTE_WL + COE_FRAC_WL;
   localparam int unsigned OW    = OUT_INTE_WL + OUT_FRAC_WL;
   localparam int unsigned AW    = idx_w(NUM_TAPS);
   localparam int unsigned PW    = prod_w(COE_INTE_WL, COE_FRAC_WL, IN_INTE_WL, IN_FRAC_WL);
   localparam int unsigned PSH   = COE_FRAC_WL + IN_FRAC_WL - ACC_FRAC_WL;
   localparam int unsigned TW    = PW - PSH;
   localparam int unsigned ACC_W = acc_w(COE_INTE_WL, IN_INTE_WL, NUM_TAPS, ACC_FRAC_WL);

   state_t            state_q, state_d;
   logic [IW-1:0]     x_q [NUM_TAPS];
   logic [CW-1:0]     c_q [NUM_TAPS];
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [AW-1:0]     k_q, k_d;
   logic [OW-1:0]     dout_q;
   logic              sat_q;

   logic [IW-1:0]     x_k;
   logic [CW-1:0]     c_k;
   logic signed [PW-1:0] prod;
   logic [ACC_W-1:0]  prod_ext;
   logic [ACC_W-1:0]  acc_sum;
   logic              last_tap;
   logic              accept;
   logic              coe_wr_ok;
   logic              load_out;
   logic [OW-1:0]     q_data;
   logic              q_sat;
   logic              unused_prod;

   assign x_k = x_q[k_q];
   assign c_k = c_q[k_q];

   assign prod = $signed({{CW{x_k[IW-1]}}, x_k}) * $signed({{IW{c_k[CW-1]}}, c_k});
   // Keep the top TW bits (floor to ACC_FRAC_WL), then sign-extend into the accumulator.
   assign prod_ext    = {{(ACC_W-TW){prod[PW-1]}}, prod[PW-1:PSH]};
   assign acc_sum     = acc_q + prod_ext;
   assign unused_prod = ^prod;

   assign last_tap  = (k_q == AW'(NUM_TAPS - 1));
   assign accept    = in_valid && (state_q == IDLE);
   assign coe_wr_ok = coe_wr_en && (state_q == IDLE) &&
                      ({{(32-AW){1'b0}}, coe_wr_addr} < NUM_TAPS);

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      k_d      = k_q;
      load_out = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               acc_d   = '0;
               k_d     = '0;
               state_d = MAC;
            end
         end
         MAC: begin
            acc_d = acc_sum;
            k_d   = k_q + AW'(1);
            if (last_tap) begin
               state_d  = OUT;
               load_out = 1'b1;
            end
         end
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Quantise the final sum so data_out is already valid on the first OUT cycle.
   fir_out_quant #(
      .ACC_W      (ACC_W),
      .ACC_FRAC_WL(ACC_FRAC_WL),
      .OUT_INTE_WL(OUT_INTE_WL),
      .OUT_FRAC_WL(OUT_FRAC_WL),
      .SAT_EN     (SAT_EN)
   ) u_quant (
      .acc_i (acc_sum),
      .data_o(q_data),
      .sat_o (q_sat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         k_q     <= '0;
         dout_q  <= '0;
         sat_q   <= 1'b0;
         for (int i = 0; i < NUM_TAPS; i++) begin
            x_q[i] <= '0;
            c_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         k_q     <= k_d;
         if (load_out) begin
            dout_q <= q_data;
            sat_q  <= q_sat;
         end
         if (accept) begin
            x_q[0] <= data_in;
            for (int i = 1; i < NUM_TAPS; i++) x_q[i] <= x_q[i-1];
         end
         if (coe_wr_ok) c_q[coe_wr_addr] <= coe_wr_data;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == OUT);
   assign data_out  = dout_q;
   assign sat_flag  = sat_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
module tb_fir_serial_mac;

   localparam int NT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] data_in = '0;
   logic        in_valid = 1'b0;
   logic        coe_wr_en = 1'b0;
   logic [1:0]  coe_wr_addr = '0;
   logic [11:0] coe_wr_data = '0;
   logic        out_ready = 1'b1;

   logic        in_ready_s, out_valid_s, sat_flag_s;
   logic [11:0] data_out_s;
   logic        in_ready_w, out_valid_w, sat_flag_w;
   logic [11:0] data_out_w;

   int tests = 0;
   int fails = 0;

   // Reference model: newest sample at index 0, exact integer arithmetic.
   int          hist[$];
   int          coef[NT];
   logic [11:0] exp_last_s;

   always #5 clk = ~clk;

   fir_serial_mac #(
      .NUM_TAPS(NT), .COE_INTE_WL(4), .COE_FRAC_WL(8), .IN_INTE_WL(4), .IN_FRAC_WL(8),
      .OUT_INTE_WL(4), .OUT_FRAC_WL(8), .ACC_FRAC_WL(16), .SAT_EN(1'b1)
   ) dut_s (
      .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready_s),
      .coe_wr_en(coe_wr_en), .coe_wr_addr(coe_wr_addr), .coe_wr_data(coe_wr_data),
      .data_out(data_out_s), .out_valid(out_valid_s), .out_ready(out_ready),
      .sat_flag(sat_flag_s)
   );

   fir_serial_mac #(
      .NUM_TAPS(NT), .COE_INTE_WL(4), .COE_FRAC_WL(8), .IN_INTE_WL(4), .IN_FRAC_WL(8),
      .OUT_INTE_WL(4), .OUT_FRAC_WL(8), .ACC_FRAC_WL(16), .SAT_EN(1'b0)
   ) dut_w (
      .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready_w),
      .coe_wr_en(coe_wr_en), .coe_wr_addr(coe_wr_addr), .coe_wr_data(coe_wr_data),
      .data_out(data_out_w), .out_valid(out_valid_w), .out_ready(out_ready),
      .sat_flag(sat_flag_w)
   );

   function automatic int sx12(input logic [11:0] v);
      return int'($signed(v));
   endfunction

   function automatic longint model_acc();
      longint a = 0;
      for (int k = 0; k < NT; k++)
         if (k < hist.size()) a += longint'(hist[k]) * longint'(coef[k]);
      return a;
   endfunction

   function automatic void model_push(input logic [11:0] x);
      hist.push_front(sx12(x));
      if (hist.size() > NT) void'(hist.pop_back());
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr_coef(input logic [1:0] a, input logic [11:0] d, input bit in_idle);
      @(negedge clk);
      coe_wr_en   = 1'b1;
      coe_wr_addr = a;
      coe_wr_data = d;
      @(posedge clk);
      if (in_idle) coef[a] = sx12(d);
      #1 coe_wr_en = 1'b0;
   endtask

   task automatic send(input logic [11:0] x);
      int n = 0;
      @(negedge clk);
      while (!in_ready_s && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", in_ready_s, 1);
      in_valid = 1'b1;
      data_in  = x;
      @(posedge clk);
      model_push(x);
      #1 in_valid = 1'b0;
   endtask

   task automatic collect(input string tag, input int skip);
      int          cyc;
      longint      q;
      logic [11:0] es, ew;
      logic        fs;
      cyc = skip;
      do begin
         @(negedge clk);
         cyc++;
      end while (!out_valid_s && cyc < skip + 50);
      check({tag, "_lat"}, cyc, 5);
      q  = model_acc() >>> 8;
      ew = q[11:0];
      fs = 1'b0;
      if (q > 2047) begin
         es = 12'h7FF;
         fs = 1'b1;
      end else if (q < -2048) begin
         es = 12'h800;
         fs = 1'b1;
      end else begin
         es = q[11:0];
      end
      exp_last_s = es;
      check({tag, "_ds"}, data_out_s, es);
      check({tag, "_fs"}, sat_flag_s, fs);
      check({tag, "_vw"}, out_valid_w, 1);
      check({tag, "_dw"}, data_out_w, ew);
      check({tag, "_fw"}, sat_flag_w, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [11:0] y;
      for (int i = 0; i < NT; i++) coef[i] = 0;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready", in_ready_s, 1);
      check("rst_out_valid", out_valid_s, 0);
      check("rst_data_out", data_out_s, 0);
      check("rst_sat_flag", sat_flag_s, 0);

      // Impulse response with unit coefficients
      for (int i = 0; i < NT; i++) wr_coef(2'(i), 12'h100, 1'b1);
      send(12'h100);
      collect("imp0", 0);
      check("imp0_const", data_out_s, 12'h100);
      for (int i = 1; i < 5; i++) begin
         send(12'h000);
         collect($sformatf("imp%0d", i), 0);
      end
      check("imp4_const", data_out_s, 12'h000);
      // Idle with in_valid low: no output, data held
      repeat (4) @(negedge clk);
      check("idle_valid", out_valid_s, 0);
      check("idle_ready", in_ready_s, 1);
      check("idle_hold", data_out_s, exp_last_s);

      // Saturation, positive then negative
      for (int i = 0; i < 4; i++) begin
         send(12'h700);
         collect($sformatf("satp%0d", i), 0);
      end
      check("satp_const", data_out_s, 12'h7FF);
      check("satp_wrap_const", data_out_w, 12'hC00);
      for (int i = 0; i < 4; i++) begin
         send(12'h800);
         collect($sformatf("satn%0d", i), 0);
      end
      check("satn_const", data_out_s, 12'h800);
      check("satn_flag_const", sat_flag_s, 1);

      // Floor rounding with c0 = 0.5
      wr_coef(2'd0, 12'h080, 1'b1);
      for (int i = 1; i < NT; i++) wr_coef(2'(i), 12'h000, 1'b1);
      send(12'h001);
      collect("floor_pos", 0);
      check("floor_pos_const", data_out_s, 12'h000);
      send(12'hFFF);
      collect("floor_neg", 0);
      check("floor_neg_const", data_out_s, 12'hFFF);

      // Randomised coefficients (within +/-1.0) and samples
      for (int i = 0; i < NT; i++) wr_coef(2'(i), 12'($urandom_range(0, 511) - 256), 1'b1);
      for (int i = 0; i < 10; i++) begin
         send(12'($urandom_range(0, 4095)));
         collect($sformatf("rnd%0d", i), 0);
      end

      // Back-pressure: stall 10 cycles with a pending sample offered
      for (int i = 0; i < NT; i++) wr_coef(2'(i), 12'h100, 1'b1);
      out_ready = 1'b0;
      send(12'h0C0);
      collect("bp", 0);
      y        = 12'($urandom_range(0, 4095));
      in_valid = 1'b1;
      data_in  = y;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("bp_hold%0d", i), data_out_s, exp_last_s);
         check($sformatf("bp_nordy%0d", i), in_ready_s, 0);
         check($sformatf("bp_valid%0d", i), out_valid_s, 1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_rel_valid", out_valid_s, 0);
      check("bp_rel_ready", in_ready_s, 1);
      @(posedge clk);
      model_push(y);
      #1 in_valid = 1'b0;
      collect("bp_next", 0);

      // Coefficient write during MAC must be ignored
      send(12'h100);
      @(negedge clk);
      wr_coef(2'd1, 12'h200, 1'b0);
      collect("guard0", 2);
      send(12'h080);
      collect("guard1", 0);
      wr_coef(2'd1, 12'h200, 1'b1);
      send(12'h040);
      collect("guard2", 0);

      // Reset during MAC clears everything
      send(12'h300);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mrst_valid", out_valid_s, 0);
      check("mrst_data", data_out_s, 0);
      check("mrst_sat", sat_flag_s, 0);
      check("mrst_data_w", data_out_w, 0);
      hist.delete();
      for (int i = 0; i < NT; i++) coef[i] = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NT; i++) wr_coef(2'(i), 12'h100, 1'b1);
      send(12'h100);
      collect("rimp0", 0);
      check("rimp0_const", data_out_s, 12'h100);
      for (int i = 1; i < 5; i++) begin
         send(12'h000);
         collect($sformatf("rimp%0d", i), 0);
      end
      check("rimp4_const", data_out_s, 12'h000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
